// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int unsigned PS2_ENTRY_W = 10;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_entry_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Show-ahead FIFO; a push while full is still accepted when a pop happens in the same cycle.
module ps2_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_pop;
    logic             do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin sync, frame deserializer, E0/F0 prefix folding, event FIFO.
// Define PS2_PARITY_CHECK_EN to reject bad-parity frames and report them on parity_err.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       out_ready,
    input  logic       clr_err,
    output logic       out_valid,
    output logic [7:0] scan_code,
    output logic       is_break,
    output logic       is_ext,
    output logic       overflow,
    output logic       parity_err
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic            clk_prev_q;
    logic            fall_c;
    logic            data_c;
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_c;
    ps2_state_e      state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [7:0]      byte_q;
    logic            byte_vld_q;
    logic            par_ok_c;
    logic            ext_pend_q;
    logic            brk_pend_q;
    logic            overflow_q;
    logic            push_c;
    logic            pop_c;
    logic            fifo_full;
    logic            fifo_empty;
    ps2_entry_t      entry_c;
    ps2_entry_t      head;

    // Synchronizers idle high so reset release never fakes a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign fall_c    = clk_prev_q & ~clk_sync_q[1];
    assign data_c    = data_sync_q[1];
    assign timeout_c = (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (fall_c) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;
    logic parity_err_q;

    assign par_ok_c   = ^{shift_q, par_q};
    assign parity_err = parity_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (fall_c && state_q == ST_PARITY) begin
                par_q <= data_c;
            end
            parity_err_q <= (fall_c && state_q == ST_STOP && !par_ok_c) |
                            (parity_err_q & ~clr_err);
        end
    end
`else
    assign par_ok_c   = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Frame FSM advances only on detected ps2_clk falling edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            if (fall_c) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!data_c) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {data_c, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'(1);
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: state_q <= ST_STOP;
                    ST_STOP: begin
                        state_q    <= ST_IDLE;
                        byte_q     <= shift_q;
                        byte_vld_q <= data_c & par_ok_c;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end else if (timeout_c) begin
                state_q <= ST_IDLE;
            end
        end
    end

    assign push_c  = byte_vld_q && (byte_q != PS2_PREFIX_EXT) && (byte_q != PS2_PREFIX_BRK);
    assign pop_c   = out_valid & out_ready;
    assign entry_c = '{ext: ext_pend_q, brk: brk_pend_q, code: byte_q};

    // Prefix folding; pending flags clear on every non-prefix byte, even a dropped one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (byte_vld_q) begin
                if (byte_q == PS2_PREFIX_EXT) begin
                    ext_pend_q <= 1'b1;
                end else if (byte_q == PS2_PREFIX_BRK) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    ext_pend_q <= 1'b0;
                    brk_pend_q <= 1'b0;
                end
            end
            overflow_q <= (push_c & fifo_full & ~pop_c) | (overflow_q & ~clr_err);
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .data_i  (entry_c),
        .pop_i   (pop_c),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign scan_code = head.code;
    assign is_break  = head.brk;
    assign is_ext    = head.ext;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: bit-banged PS/2 frames in, queued expected events out.
module tb_ps2_keyboard_rx;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned TIMEOUT    = 300;
    localparam int unsigned HALF       = 20;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       out_ready = 1'b0;
    logic       clr_err   = 1'b0;
    logic       out_valid;
    logic [7:0] scan_code;
    logic       is_break;
    logic       is_ext;
    logic       overflow;
    logic       parity_err;

    int         checks       = 0;
    int         errors       = 0;
    int         valid_cycles = 0;
    logic [9:0] exp_q [$];

    ps2_keyboard_rx #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .out_ready  (out_ready),
        .clr_err    (clr_err),
        .out_valid  (out_valid),
        .scan_code  (scan_code),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic send_partial(input logic [7:0] b);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            tick(1);
            n++;
        end
        tick(4);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            valid_cycles++;
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_entry", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    check_eq("entry", {22'd0, is_ext, is_break, scan_code}, {22'd0, e});
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick(5);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_code",  32'(scan_code), 32'd0);
        check_eq("rst_flags", {30'd0, is_ext, is_break}, 32'd0);
        check_eq("rst_ovf",   32'(overflow), 32'd0);
        check_eq("rst_perr",  32'(parity_err), 32'd0);
        rst_n = 1'b1;
        tick(10);

        // Plain make code: one entry, out_valid high for exactly one cycle.
        out_ready    = 1'b1;
        valid_cycles = 0;
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0);
        wait_drain("make_drain");
        check_eq("make_pulse", 32'(valid_cycles), 32'd1);

        // Break code.
        exp_q.push_back(10'h11C);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        wait_drain("break_drain");

        // Extended break, then flags clear on the next make.
        exp_q.push_back(10'h375);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        exp_q.push_back(10'h01D);
        send_frame(8'h1D, 1'b0);
        wait_drain("ext_drain");

        // Fill past capacity with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < int'(FIFO_DEPTH)) exp_q.push_back({2'b00, 8'(8'h15 + i)});
            send_frame(8'(8'h15 + i), 1'b0);
        end
        tick(5);
        check_eq("ovf_valid", 32'(out_valid), 32'd1);
        check_eq("ovf_head",  32'(scan_code), 32'h15);
        check_eq("ovf_flag",  32'(overflow), 32'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
        check_eq("ovf_clear", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        wait_drain("ovf_drain");
        check_eq("ovf_empty", 32'(out_valid), 32'd0);

        // Bad parity.
`ifdef PS2_PARITY_CHECK_EN
        send_frame(8'h15, 1'b1);
        wait_drain("par_drain");
        check_eq("par_flag", 32'(parity_err), 32'd1);
`else
        exp_q.push_back(10'h015);
        send_frame(8'h15, 1'b1);
        wait_drain("par_drain");
        check_eq("par_flag", 32'(parity_err), 32'd0);
`endif
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
        check_eq("par_clear", 32'(parity_err), 32'd0);

        // Partial frame abandoned by timeout, then a clean frame.
        send_partial(8'hA5);
        tick(TIMEOUT + 100);
        check_eq("to_no_entry", 32'(out_valid), 32'd0);
        exp_q.push_back(10'h024);
        send_frame(8'h24, 1'b0);
        wait_drain("to_drain");

        // Partial frame lost to reset, then a clean frame.
        send_partial(8'h5A);
        rst_n = 1'b0;
        tick(3);
        check_eq("mrst_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        tick(5);
        exp_q.push_back(10'h024);
        send_frame(8'h24, 1'b0);
        wait_drain("mrst_drain");
        check_eq("final_ovf", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

PS/2 keyboard front end that turns raw `ps2_clk`/`ps2_data` pin activity into queued scan-code events for the scan-code-to-ASCII lookup stage directly downstream. It synchronizes the pins, deserializes 11-bit device-to-host frames, folds the `E0` (extended) and `F0` (break) prefix bytes into flags, and buffers events in a small FIFO behind a valid/ready handshake. The `scan_code` output feeds the lookup stage's `scan_code` input unchanged.

## Interface
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of two and at least 2.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is abandoned.
- `clk` in 1: system clock, the block's only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` in 1: PS/2 data pin, asynchronous to `clk`.
- `out_ready` in 1: the consumer accepts the head entry.
- `clr_err` in 1: synchronous clear of the sticky error flags.
- `out_valid` out 1: the FIFO is non-empty.
- `scan_code` out 8: scan code of the head entry (prefixes stripped).
- `is_break` out 1: the head entry was preceded by `F0`.
- `is_ext` out 1: the head entry was preceded by `E0`.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.
- `parity_err` out 1: sticky; a frame was rejected for bad parity.

## Operation
- **Pin synchronization:** both pins pass through a 2-flop synchronizer. A third register on the synchronized clock detects a falling edge as `prev & ~cur`.
- **Frame FSM.** All transitions occur only on a detected falling edge.
  - IDLE: if data is 0 (start bit), go to DATA with `bit_cnt=0`. If data is 1, stay in IDLE.
  - DATA: shift data in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: go to IDLE. The byte is accepted only if the stop bit is 1 and parity is odd (`^{byte,p}==1`). Otherwise the frame is discarded.
- **Timeout:** a counter clears on every falling edge. In any state other than IDLE, reaching `TIMEOUT_CYCLES-1` forces IDLE and discards the partial frame. The counter saturates in IDLE.
- **Prefix handling** for each accepted byte:
  - `E0` sets `ext_pend`.
  - `F0` sets `brk_pend`.
  - Any other byte pushes `{ext_pend, brk_pend, byte}` and clears both pending flags.
  - Prefix bytes are never queued. A discarded frame does not alter the pending flags.
- **FIFO:** show-ahead. The outputs always reflect the head entry.
  - A pop happens when `out_valid & out_ready`.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the push is dropped: `overflow` is set, and the pending flags still clear.
- **Error flags:** `clr_err` clears `overflow` and `parity_err`. If a set condition and `clr_err` occur in the same cycle, the set wins.
- **Reset:** all outputs are 0, the FSM is in IDLE, the FIFO is empty, and the pending flags and counters are cleared. Asserting reset mid-frame loses the frame. The frame after reset must start from a clean start bit.

## Timing
- From a pin falling edge to a detected edge: 3 `clk` rising edges (2 synchronizer stages plus the edge register).
- Stop-bit edge detected in cycle E: the accept/prefix decision registers at the end of E.
- The FIFO write occurs at the end of E+1, so `out_valid` is high from cycle E+2.
- A pop takes effect at the clock edge. The next entry appears in the following cycle with zero bubbles.
- The design supports PS/2 clocks of 10–16.7 kHz with `clk` ≥ 1 MHz.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: frames with bad parity are discarded and set `parity_err`.
- Undefined: the parity bit is captured but ignored, and `parity_err` is tied to 0. A bad stop bit still discards the frame.

## Structure
- Package `ps2_pkg` holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - constants `PS2_PREFIX_EXT=8'hE0` and `PS2_PREFIX_BRK=8'hF0`;
  - the packed 10-bit entry struct `{ext, brk, code[7:0]}`.
- Sub-module `ps2_rx_fifo`: parameterized show-ahead FIFO with push/pop, full/empty, and same-cycle push-when-full-with-pop support.

## Test plan
- Frame `0x1C` with correct parity, `out_ready=1`: `out_valid` pulses for 1 cycle with `scan_code=0x1C`, `is_break=0`, `is_ext=0`.
- Frames `F0`, `1C`: exactly one entry, `0x1C` with `is_break=1`, `is_ext=0`.
- Frames `E0`, `F0`, `75`: one entry, `0x75` with `is_ext=1` and `is_break=1`. The next frame `1D` yields flags 0/0.
- Nine make codes `0x15..0x1D` with `out_ready=0`: 8 entries, `0x15..0x1C` in order; `overflow=1`; `0x1D` is lost. `clr_err` then returns `overflow` to 0.
- Frame `0x15` with flipped parity:
  - macro defined: no entry, `parity_err=1`;
  - macro undefined: entry `0x15`, `parity_err=0`.
- 4 data bits followed by `ps2_clk` held high for more than `TIMEOUT_CYCLES`: no entry. A following full frame `0x24` is received correctly. Repeat with `rst_n` pulsed mid-frame and expect the same result.
